// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game sequencer: colour codes, FSM state
// encoding and the lamp one-hot helper.
package simon_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle.
// Kept standalone so a future random-tone block can share it.
module simon_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       SYS_CLK,
    input  logic       RESET,
    output logic [7:0] state
);

    always_ff @(posedge SYS_CLK) begin
        if (RESET) state <= SEED;
        else       state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game sequencer: grows a random colour sequence, plays it on the lamps,
// then checks the player's replay and moves to the next level, WIN or LOSE.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         ON_CYC      = 8,
    parameter int         OFF_CYC     = 4,
    parameter int         TIMEOUT_CYC = 64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    localparam int        LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          SYS_CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic          green,
    input  logic          red,
    input  logic          yellow,
    input  logic          blue,
    output logic [3:0]    lamp,
    output logic [LW-1:0] level,
    output logic          wait_input,
    output logic          win,
    output logic          lose
);

    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (TIMEOUT_CYC > ON_CYC) ?
                          ((TIMEOUT_CYC > OFF_CYC) ? TIMEOUT_CYC : OFF_CYC) :
                          ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T1       = TW'(1);
    localparam logic [LW-1:0] L1       = LW'(1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    state_t        state;
    logic [LW-1:0] idx;
    logic [LW-1:0] idx_inc;
    logic [TW-1:0] timer;
    logic [1:0]    mem [MAX_LEN];
    logic [7:0]    lfsr;
    logic          lfsr_unused;
    logic [3:0]    btn;
    logic [1:0]    btn_col;
    logic          last;
    logic          hit;
    logic [1:0]    first_col;

    simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .SYS_CLK (SYS_CLK),
        .RESET   (RESET),
        .state   (lfsr)
    );

    // Only the low two LFSR bits pick a colour.
    assign lfsr_unused = ^lfsr[7:2];

    assign btn     = {blue, yellow, red, green};
    assign idx_inc = idx + L1;
    assign last    = (idx == level - L1);

    always_comb begin
        btn_col = 2'd0;
        for (int i = 0; i < 4; i++)
            if (btn[i]) btn_col = 2'(i);
    end

    assign hit = $onehot(btn) && (btn_col == mem[idx[IW-1:0]]);

    // mem[0] is still being written when the very first colour is added.
    assign first_col = (level == '0) ? lfsr[1:0] : mem[0];

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state      <= IDLE;
            level      <= '0;
            idx        <= '0;
            timer      <= '0;
            lamp       <= '0;
            wait_input <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state <= ADD;
                        level <= '0;
                        lamp  <= '0;
                        win   <= 1'b0;
                        lose  <= 1'b0;
                    end
                end
                ADD: begin
                    mem[level[IW-1:0]] <= lfsr[1:0];
                    level <= level + L1;
                    idx   <= '0;
                    timer <= '0;
                    lamp  <= onehot(first_col);
                    state <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer == ON_LAST) begin
                        timer <= '0;
                        lamp  <= '0;
                        state <= SHOW_OFF;
                    end else begin
                        timer <= timer + T1;
                    end
                end
                SHOW_OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (last) begin
                            idx        <= '0;
                            wait_input <= 1'b1;
                            state      <= WAIT_IN;
                        end else begin
                            idx   <= idx_inc;
                            lamp  <= onehot(mem[idx_inc[IW-1:0]]);
                            state <= SHOW_ON;
                        end
                    end else begin
                        timer <= timer + T1;
                    end
                end
                WAIT_IN: begin
                    if (btn != '0) begin
                        if (!hit) begin
                            lose       <= 1'b1;
                            wait_input <= 1'b0;
                            state      <= LOSE;
                        end else if (!last) begin
                            idx   <= idx_inc;
                            timer <= '0;
                        end else if (level == LEN_MAX) begin
                            win        <= 1'b1;
                            lamp       <= 4'hF;
                            wait_input <= 1'b0;
                            state      <= WIN;
                        end else begin
                            wait_input <= 1'b0;
                            state      <= ADD;
                        end
                    end else if (timer == TO_LAST) begin
                        lose       <= 1'b1;
                        wait_input <= 1'b0;
                        state      <= LOSE;
                    end else begin
                        timer <= timer + T1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
Game sequencer for the Simon memory game. Generates a random colour sequence and plays it back on the four lamps. It then collects the player's button presses, compares each one against the stored sequence, and advances the level, or declares a win or a loss. It sits between the debounced button pulses and the lamp/display drivers, and owns all game state.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it with a correct replay wins the game
ON_CYC, 8, cycles each lamp is lit during playback (>=1)
OFF_CYC, 4, dark cycles after each playback lamp (>=1)
TIMEOUT_CYC, 64, idle cycles allowed in WAIT_IN before a loss
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a new game (IDLE/WIN/LOSE only)
green  in  1  one-cycle button pulse, colour code 0
red  in  1  one-cycle button pulse, colour code 1
yellow  in  1  one-cycle button pulse, colour code 2
blue  in  1  one-cycle button pulse, colour code 3
lamp  out  4  one-hot lamp drive, bit index = colour code
level  out  LW=$clog2(MAX_LEN+1)  current sequence length
wait_input  out  1  high while in WAIT_IN
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- Reset (RESET=1 at an edge, any state): state=IDLE, level=0, idx=0, timer=0, LFSR=LFSR_SEED. All outputs are 0 from the next cycle. Sequence memory is don't-care.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle in every state. The new colour is lfsr[1:0].
- Sequence memory: MAX_LEN x 2 bits. It is written only in ADD.
- Outputs are registered. A decision made at edge N is visible in cycle N+1.
- IDLE: lamp=0. start -> ADD, with level cleared to 0.
- ADD (1 cycle): mem[level] <= lfsr[1:0], level++, idx=0, timer=0 -> SHOW_ON.
- SHOW_ON: lamp=onehot(mem[idx]) for exactly ON_CYC cycles -> SHOW_OFF with timer=0.
- SHOW_OFF: lamp=0 for exactly OFF_CYC cycles.
  - If idx==level-1: -> WAIT_IN with idx=0, timer=0.
  - Otherwise: idx++ -> SHOW_ON.
- WAIT_IN: lamp=0, wait_input=1. The timer counts cycles without any button press.
  - Exactly one button, colour==mem[idx], idx<level-1: idx++, timer=0, stay in WAIT_IN.
  - Exactly one button, match, idx==level-1, level<MAX_LEN: -> ADD.
  - Exactly one button, match, idx==level-1, level==MAX_LEN: -> WIN.
  - Wrong colour, or two or more buttons in the same cycle: -> LOSE.
  - timer reaches TIMEOUT_CYC-1 with no press: -> LOSE.
- WIN: win=1, lamp=4'hF. LOSE: lose=1, lamp=0. Both hold until start, which begins a new game (level cleared, -> ADD).
- level holds its final value in WIN/LOSE.
- Buttons are ignored outside WAIT_IN. start is ignored in ADD/SHOW_ON/SHOW_OFF/WAIT_IN.
- RESET has priority over start and all buttons in the same cycle.

Decomposition:
- Package simon_pkg holds:
  - colour codes GREEN=0, RED=1, YELLOW=2, BLUE=3
  - the 3-bit state encoding (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE)
  - the onehot(colour) function
- One sub-module: simon_lfsr (SYS_CLK, RESET, SEED parameter, 8-bit state out). It is shared with any future random-tone block.
- The FSM, sequence memory, timer and comparison stay in simon_game_ctrl.

Test Plan:
1. RESET 2 cycles, start pulse -> level=1 one cycle after ADD; lamp one-hot for exactly 8 cycles, then 0 for 4 cycles; then wait_input=1. The colour matches the model LFSR from seed 8'hA5.
2. Replay the colours observed on lamp correctly for levels 1..3 -> level goes 1,2,3. Each playback repeats the earlier colours unchanged and appends one new colour.
3. At level 2, press the wrong colour for idx 0 -> next cycle lose=1, wait_input=0, lamp=0, level=2. A later start -> level=1 and a fresh playback.
4. In WAIT_IN, red+blue in the same cycle -> lose=1. A separate run with no press for 64 cycles -> lose=1 on cycle 65. Buttons pressed during SHOW_ON are ignored (no state change).
5. MAX_LEN=4: correct replays through level 4 -> win=1, lamp=4'hF, level=4, holding until start.
6. RESET asserted mid-SHOW_ON at level 3 -> next cycle lamp=0, level=0, win=lose=wait_input=0, state IDLE. Buttons are ignored until start.
